// File: rtl/bram_snapshot_asym.sv
// Snapshot buffer: wide capture port under an arm/trigger FSM (one-shot or
// circular pre-trigger capture) plus a narrow, optionally registered readback.
module bram_snapshot_asym #(
  parameter  int unsigned WIDE_DW   = 128,
  parameter  int unsigned NARROW_DW = 32,
  parameter  int unsigned WIDE_AW   = 13,
  parameter  int unsigned OUT_REG   = 0,
  localparam int unsigned RATIO     = WIDE_DW / NARROW_DW,
  localparam int unsigned LOG_R     = $clog2(RATIO),
  localparam int unsigned NARROW_AW = WIDE_AW + LOG_R
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 circ,
  input  logic [WIDE_AW-1:0]   post_len,
  input  logic                 trig,
  input  logic                 din_vld,
  input  logic [WIDE_DW-1:0]   din,
  output logic                 busy,
  output logic                 done,
  output logic                 wrapped,
  output logic [WIDE_AW-1:0]   wr_ptr,
  input  logic                 rd_en,
  input  logic [NARROW_AW-1:0] rd_addr,
  output logic [NARROW_DW-1:0] rd_data,
  output logic                 rd_vld
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPT, S_POST, S_DONE} state_t;

  state_t               state;
  logic                 circ_q;
  logic [WIDE_AW-1:0]   post_len_q;
  logic [WIDE_AW-1:0]   post_cnt;
  logic                 we;
  logic [WIDE_DW-1:0]   mem [2**WIDE_AW];

  logic [WIDE_AW-1:0]   rd_idx;
  logic [NARROW_AW-1:0] rd_lane;
  logic [WIDE_DW-1:0]   rd_word;
  logic [NARROW_DW-1:0] rd_d1;
  logic                 vld1;

  // Write enable: arm suppresses the write; one-shot ARMED only writes the trigger word
  always_comb begin
    we = 1'b0;
    if (!arm && din_vld) begin
      unique case (state)
        S_ARMED: we = circ_q || trig;
        S_CAPT,
        S_POST:  we = 1'b1;
        default: we = 1'b0;
      endcase
    end
  end

  // Capture control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrapped    <= 1'b0;
      wr_ptr     <= '0;
      post_cnt   <= '0;
      circ_q     <= 1'b0;
      post_len_q <= '0;
    end else if (arm) begin
      state      <= S_ARMED;
      busy       <= 1'b1;
      done       <= 1'b0;
      wrapped    <= 1'b0;
      wr_ptr     <= '0;
      post_cnt   <= '0;
      circ_q     <= circ;
      post_len_q <= post_len;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == '1) wrapped <= 1'b1;
      end
      unique case (state)
        S_ARMED: begin
          if (trig) begin
            if (!circ_q) begin
              state <= S_CAPT;
            end else if (post_len_q == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_CAPT: begin
          if (we && wr_ptr == '1) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_POST: begin
          if (we) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == post_len_q) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Wide write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end

  // Narrow address split into wide word index and lane select
  always_comb begin
    rd_idx  = WIDE_AW'(rd_addr >> LOG_R);
    rd_lane = rd_addr & NARROW_AW'(RATIO - 1);
    rd_word = mem[rd_idx];
  end

  // First read stage; sampling RAM before the write lands gives read-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1  <= 1'b0;
      rd_d1 <= '0;
    end else begin
      vld1 <= rd_en;
      if (rd_en) rd_d1 <= rd_word[rd_lane * NARROW_DW +: NARROW_DW];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NARROW_DW-1:0] rd_d2;
      logic                 vld2;
      // Optional output stage; data only advances with a valid word so it holds otherwise
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld2  <= 1'b0;
          rd_d2 <= '0;
        end else begin
          vld2 <= vld1;
          if (vld1) rd_d2 <= rd_d1;
        end
      end
      assign rd_data = rd_d2;
      assign rd_vld  = vld2;
    end else begin : g_no_out_reg
      assign rd_data = rd_d1;
      assign rd_vld  = vld1;
    end
  endgenerate

endmodule
